mem1_stage: RTL and testbench
=============================

MEM1_STAGE -- requirements
Module: mem1_stage

Interface
- REQ-001 SHALL have parameter LSU_WD, default 8, width of the lsu_op field; bits [4:0] are one-hot lb, lbu, lh, lhu, lw, and higher bits are store ops that this stage ignores.
- REQ-002 SHALL use one clock; reset is asynchronous and active-high.
- REQ-003 clk  in  1  rising-edge clock.
- REQ-004 rst  in  1  asynchronous, active-high reset.
- REQ-005 stall  in  6  pipeline stall vector; bit 4 = this stage, bit 5 = next stage.
- REQ-006 stallreq_mem  out  1  stall request while a load waits for memory data.
- REQ-007 ex2mem1_bus  in  LSU_WD+109  fields MSB to LSB: {lsu_op, data_ram_sel[3:0], sel_rf_res[2:0], rf_we, rf_waddr[4:0], ex_result[31:0], pc[31:0], inst[31:0]}.
- REQ-008 data_sram_rdata  in  32  load data from the data SRAM.
- REQ-009 data_sram_rvalid  in  1  data_sram_rdata is valid this cycle.
- REQ-010 mem12wb_bus  out  102  {rf_we, rf_waddr[4:0], rf_wdata[31:0], pc[31:0], inst[31:0]}.
- REQ-011 mem12rf_bus  out  38  bypass bus {rf_we, rf_waddr[4:0], rf_wdata[31:0]}, combinational from the same values as mem12wb_bus.
- REQ-012 load_misalign  out  1  misaligned load flag (see Configuration).

Function
- REQ-013 Pipeline register: if stall[4]=1 and stall[5]=0, SHALL load all-zero (bubble); else if stall[4]=0, SHALL capture ex2mem1_bus; otherwise it SHALL hold its value.
- REQ-014 "Load in stage" = OR of registered lsu_op[4:0]; "advance" = stall[4]=0 or (stall[4]=1 and stall[5]=0).
- REQ-015 FSM states:
  - IDLE: no load pending.
  - WAIT: load in stage, data not yet received.
  - HELD: data captured.
- REQ-016 FSM transitions:
  - IDLE -> WAIT: load enters the register and rvalid is 0 in the next cycle.
  - IDLE/WAIT -> HELD: load in stage, rvalid=1 and no advance.
  - WAIT/HELD -> IDLE: on advance.
- REQ-017 While a load is in stage, rvalid=1 and the state is not HELD, the stage SHALL capture data_sram_rdata into a 32-bit hold register.
- REQ-018 Effective load word SHALL be data_sram_rdata when rvalid=1 and the state is not HELD, otherwise the hold register.
- REQ-019 stallreq_mem SHALL be 1 exactly when a load is in stage, the state is not HELD and rvalid=0 (combinational).
- REQ-020 Byte selection: lb/lbu take the byte whose data_ram_sel bit is set; lh/lhu take the half at sel 0011 -> [15:0] and sel 1100 -> [31:16]; lw takes all 32 bits.
- REQ-021 lb/lh SHALL sign-extend; lbu/lhu SHALL zero-extend.
- REQ-022 rf_wdata SHALL be the load result when sel_rf_res[1]=1, else ex_result.
- REQ-023 While stallreq_mem=1, rf_we on both output buses SHALL be 0.
- REQ-024 A bubble SHALL drive all-zero buses.
- REQ-025 An rvalid pulse with no load in stage SHALL be ignored.
- REQ-026 If an advance and rvalid=1 occur in the same cycle, the stage SHALL use the live data and go to IDLE with no capture.

Reset
- REQ-027 rst=1 SHALL asynchronously clear the pipeline register, the hold register and the FSM (to IDLE).
- REQ-028 During reset, all outputs SHALL be 0, including when reset asserts mid-WAIT or mid-HELD.
- REQ-029 The first cycle after reset deassertion SHALL be a bubble.

Configuration
- REQ-030 Macro MISALIGN_CHK_EN.
- REQ-031 With MISALIGN_CHK_EN defined, load_misalign SHALL be 1 when a load is in stage and any of these holds:
  - lb/lbu with a data_ram_sel that is not one-hot;
  - lh/lhu with data_ram_sel not equal to 0011 or 1100;
  - lw with data_ram_sel not equal to 1111.
- REQ-032 With MISALIGN_CHK_EN defined, a misaligned load SHALL also force rf_we to 0 on both output buses.
- REQ-033 Without MISALIGN_CHK_EN, load_misalign SHALL be tied to 0 and rf_we SHALL be unaffected.

Verification
- REQ-034 lw, sel 1111, rf_waddr 5, rvalid=1 in the first cycle, rdata 0xDEADBEEF -> same-cycle mem12rf_bus = {1, 5, 0xDEADBEEF}; stallreq_mem stays 0.
- REQ-035 lb, sel 0100, rdata 0x0080_0000 -> rf_wdata 0xFFFFFF80; lbu with the same inputs -> 0x00000080.
- REQ-036 lh, sel 1100, rvalid held 0 for 3 cycles then 1 with rdata 0x8001_0000 -> stallreq_mem=1 for exactly 3 cycles, rf_we=0 meanwhile, then rf_wdata 0xFFFF8001.
- REQ-037 lw with rvalid=1 in the first cycle while stall[5]=1 for 2 cycles, rdata changes to 0x0 afterwards -> state HELD, rf_wdata stays at the first rdata until advance.
- REQ-038 rst pulse while in WAIT -> all outputs 0 immediately, FSM IDLE; the next non-load instruction passes ex_result unchanged.
- REQ-039 With MISALIGN_CHK_EN defined: lw, sel 0011 -> load_misalign=1 and rf_we=0. Without the macro: load_misalign=0.

Source files
------------

// File: rtl/mem1_stage.sv
// mem1_stage: first memory pipeline stage; waits for, holds and aligns load data.
// Define MISALIGN_CHK_EN to enable misaligned-load detection.
module mem1_stage #(
  parameter int LSU_WD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  output logic                stallreq_mem,
  input  logic [LSU_WD+108:0] ex2mem1_bus,
  input  logic [31:0]         data_sram_rdata,
  input  logic                data_sram_rvalid,
  output logic [101:0]        mem12wb_bus,
  output logic [37:0]         mem12rf_bus,
  output logic                load_misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

  state_t              state;
  logic [LSU_WD+108:0] bus_r;
  logic [31:0]         hold_r;

  logic [LSU_WD-1:0] lsu_op;
  logic [3:0]        data_ram_sel;
  logic [2:0]        sel_rf_res;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       ex_result;
  logic [31:0]       pc;
  logic [31:0]       inst;

  assign {lsu_op, data_ram_sel, sel_rf_res, rf_we, rf_waddr, ex_result, pc, inst} = bus_r;

  logic is_lb, is_lbu, is_lh, is_lhu, is_lw;
  logic load_in_stage, advance, live, capture;

  assign is_lb  = lsu_op[0];
  assign is_lbu = lsu_op[1];
  assign is_lh  = lsu_op[2];
  assign is_lhu = lsu_op[3];
  assign is_lw  = lsu_op[4];

  assign load_in_stage = |lsu_op[4:0];
  assign advance       = !stall[4] || !stall[5];
  // Once data is held, a later rvalid pulse no longer refers to this load.
  assign live          = data_sram_rvalid && (state != HELD);
  assign capture       = load_in_stage && live && !advance;
  assign stallreq_mem  = load_in_stage && (state != HELD) && !data_sram_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r <= '0;
    end else if (stall[4] && !stall[5]) begin
      bus_r <= '0;
    end else if (!stall[4]) begin
      bus_r <= ex2mem1_bus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hold_r <= '0;
    end else begin
      if (capture) begin
        hold_r <= data_sram_rdata;
      end
      if (advance) begin
        state <= IDLE;
      end else if (load_in_stage) begin
        if (live) begin
          state <= HELD;
        end else if (state == IDLE) begin
          state <= WAIT;
        end
      end
    end
  end

  logic [31:0] mem_word;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_res;

  always_comb begin
    mem_word = live ? data_sram_rdata : hold_r;
    case (data_ram_sel)
      4'b0001: byte_val = mem_word[7:0];
      4'b0010: byte_val = mem_word[15:8];
      4'b0100: byte_val = mem_word[23:16];
      4'b1000: byte_val = mem_word[31:24];
      default: byte_val = 8'h00;
    endcase
    half_val = (data_ram_sel == 4'b1100) ? mem_word[31:16] : mem_word[15:0];
    load_res = 32'h0;
    if (is_lb) begin
      load_res = {{24{byte_val[7]}}, byte_val};
    end else if (is_lbu) begin
      load_res = {24'h0, byte_val};
    end else if (is_lh) begin
      load_res = {{16{half_val[15]}}, half_val};
    end else if (is_lhu) begin
      load_res = {16'h0, half_val};
    end else if (is_lw) begin
      load_res = mem_word;
    end
  end

`ifdef MISALIGN_CHK_EN
  logic sel_onehot;
  logic sel_half;

  always_comb begin
    case (data_ram_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_onehot = 1'b1;
      default:                            sel_onehot = 1'b0;
    endcase
    sel_half = (data_ram_sel == 4'b0011) || (data_ram_sel == 4'b1100);
  end

  assign load_misalign = load_in_stage &&
                         (((is_lb || is_lbu) && !sel_onehot) ||
                          ((is_lh || is_lhu) && !sel_half) ||
                          (is_lw && (data_ram_sel != 4'b1111)));
`else
  assign load_misalign = 1'b0;
`endif

  logic        rf_we_out;
  logic [31:0] rf_wdata;

  assign rf_we_out   = rf_we && !stallreq_mem && !load_misalign;
  assign rf_wdata    = sel_rf_res[1] ? load_res : ex_result;
  assign mem12rf_bus = {rf_we_out, rf_waddr, rf_wdata};
  assign mem12wb_bus = {rf_we_out, rf_waddr, rf_wdata, pc, inst};

  // Store-op bits, earlier-stage stall bits and unused result selects are don't-cares here.
  logic unused_bits;
  assign unused_bits = ^{stall[3:0], lsu_op, sel_rf_res[2], sel_rf_res[0]};

endmodule

// File: tb/tb_mem1_stage.sv
// tb_mem1_stage: table vectors, directed multi-cycle sequences and a randomized
// run checked against a behavioural model of the load stage.
module tb_mem1_stage;
  localparam int LSU_WD = 8;
  localparam logic [7:0] OP_LB = 8'h01, OP_LBU = 8'h02, OP_LH = 8'h04,
                         OP_LHU = 8'h08, OP_LW = 8'h10, OP_SW = 8'h80;

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  sel;
    logic [2:0]  selrf;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] ex;
    logic [31:0] pc;
    logic [31:0] inst;
  } instr_t;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  sel;
    logic [2:0]  selrf;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] ex;
    logic        rv;
    logic [31:0] rd;
    logic        expWe;
    logic [31:0] expData;
    logic        expStall;
    logic        chkData;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [5:0]          stall;
  logic                stallreq_mem;
  logic [LSU_WD+108:0] ex2mem1_bus;
  logic [31:0]         data_sram_rdata;
  logic                data_sram_rvalid;
  logic [101:0]        mem12wb_bus;
  logic [37:0]         mem12rf_bus;
  logic                load_misalign;

  int errors = 0;
  int checks = 0;

  mem1_stage #(.LSU_WD(LSU_WD)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .stallreq_mem     (stallreq_mem),
    .ex2mem1_bus      (ex2mem1_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .mem12wb_bus      (mem12wb_bus),
    .mem12rf_bus      (mem12rf_bus),
    .load_misalign    (load_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [101:0] actual,
                             input logic [101:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] st, input instr_t ins,
                               input logic rv, input logic [31:0] rd);
    stall            = st;
    ex2mem1_bus      = ins;
    data_sram_rvalid = rv;
    data_sram_rdata  = rd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stallreq"}, 102'(stallreq_mem), 102'(0));
    checkOutput({tag, " wb bus"}, mem12wb_bus, 102'(0));
    checkOutput({tag, " rf bus"}, 102'(mem12rf_bus), 102'(0));
    checkOutput({tag, " misalign"}, 102'(load_misalign), 102'(0));
  endtask

  task automatic checkInstrOut(input string tag, input instr_t ins, input logic we,
                               input logic [31:0] wdata, input logic sreq, input logic chkData);
    checkOutput({tag, " stallreq"}, 102'(stallreq_mem), 102'(sreq));
    checkOutput({tag, " wb rf_we"}, 102'(mem12wb_bus[101]), 102'(we));
    checkOutput({tag, " rf rf_we"}, 102'(mem12rf_bus[37]), 102'(we));
    checkOutput({tag, " waddr"}, 102'(mem12rf_bus[36:32]), 102'(ins.waddr));
    checkOutput({tag, " pc"}, 102'(mem12wb_bus[63:32]), 102'(ins.pc));
    checkOutput({tag, " inst"}, 102'(mem12wb_bus[31:0]), 102'(ins.inst));
    checkOutput({tag, " misalign"}, 102'(load_misalign), 102'(0));
    if (chkData) begin
      checkOutput({tag, " wb wdata"}, 102'(mem12wb_bus[95:64]), 102'(wdata));
      checkOutput({tag, " rf wdata"}, 102'(mem12rf_bus[31:0]), 102'(wdata));
    end
  endtask

  function automatic instr_t mkInstr(input logic [7:0] op, input logic [3:0] sel,
                                     input logic [2:0] selrf, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] ex);
    instr_t i;
    i.op = op; i.sel = sel; i.selrf = selrf; i.we = we; i.waddr = waddr; i.ex = ex;
    i.pc = $urandom;
    i.inst = $urandom;
    return i;
  endfunction

  function automatic instr_t genInstr();
    instr_t i;
    int kind;
    i = '0;
    kind = $urandom_range(0, 6);
    i.waddr = 5'($urandom);
    i.ex = $urandom;
    i.pc = $urandom;
    i.inst = $urandom;
    i.we = 1'($urandom_range(0, 1));
    if (kind == 0) begin
      i.selrf = 3'b001;
    end else if (kind == 6) begin
      i.op = 8'h20; i.selrf = 3'b000; i.we = 1'b0; i.sel = 4'($urandom);
    end else begin
      i.op = 8'(1 << (kind - 1));
      i.selrf = 3'b010;
      case (kind)
        1, 2:    i.sel = 4'(1 << $urandom_range(0, 3));
        3, 4:    i.sel = ($urandom_range(0, 1) == 1) ? 4'b1100 : 4'b0011;
        default: i.sel = 4'b1111;
      endcase
      if ($urandom_range(0, 9) == 0) i.sel = 4'($urandom);
    end
    return i;
  endfunction

  function automatic bit isMisaligned(input instr_t i);
    if (i.op[0] || i.op[1]) return $countones(i.sel) != 1;
    if (i.op[2] || i.op[3]) return !(i.sel == 4'b0011 || i.sel == 4'b1100);
    if (i.op[4]) return i.sel != 4'b1111;
    return 1'b0;
  endfunction

  // Reference load extraction written as shifts and masks on the chosen lane.
  function automatic logic [31:0] loadValue(input instr_t i, input logic [31:0] w);
    logic [31:0] b, h;
    int idx;
    idx = 0;
    for (int k = 0; k < 4; k++) if (i.sel[k]) idx = k;
    b = (w >> (8 * idx)) & 32'hFF;
    h = (i.sel == 4'b1100) ? (w >> 16) : (w & 32'hFFFF);
    if (i.op[0]) return b[7] ? (b | 32'hFFFFFF00) : b;
    if (i.op[1]) return b;
    if (i.op[2]) return h[15] ? (h | 32'hFFFF0000) : h;
    if (i.op[3]) return h;
    return w;
  endfunction

  vec_t   vecs[12];
  instr_t zeroI;
  instr_t insA, insB;

  initial begin
    zeroI = '0;
    vecs[0]  = '{OP_LW,  4'b1111, 3'b010, 1'b1, 5'd5,  32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[1]  = '{OP_LB,  4'b0100, 3'b010, 1'b1, 5'd6,  32'h0,        1'b1, 32'h00800000, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1};
    vecs[2]  = '{OP_LBU, 4'b0100, 3'b010, 1'b1, 5'd7,  32'h0,        1'b1, 32'h00800000, 1'b1, 32'h00000080, 1'b0, 1'b1};
    vecs[3]  = '{OP_LH,  4'b0011, 3'b010, 1'b1, 5'd8,  32'h0,        1'b1, 32'h12348765, 1'b1, 32'hFFFF8765, 1'b0, 1'b1};
    vecs[4]  = '{OP_LHU, 4'b1100, 3'b010, 1'b1, 5'd9,  32'h0,        1'b1, 32'h80010000, 1'b1, 32'h00008001, 1'b0, 1'b1};
    vecs[5]  = '{OP_LB,  4'b1000, 3'b010, 1'b1, 5'd10, 32'h0,        1'b1, 32'h7F000000, 1'b1, 32'h0000007F, 1'b0, 1'b1};
    vecs[6]  = '{OP_LBU, 4'b0001, 3'b010, 1'b1, 5'd11, 32'h0,        1'b1, 32'h000000FF, 1'b1, 32'h000000FF, 1'b0, 1'b1};
    vecs[7]  = '{OP_LB,  4'b0010, 3'b010, 1'b1, 5'd12, 32'h0,        1'b1, 32'h0000A500, 1'b1, 32'hFFFFFFA5, 1'b0, 1'b1};
    vecs[8]  = '{8'h00,  4'b0000, 3'b001, 1'b1, 5'd13, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[9]  = '{OP_LW,  4'b1111, 3'b010, 1'b1, 5'd14, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{OP_SW,  4'b1111, 3'b000, 1'b0, 5'd0,  32'h00000400, 1'b0, 32'h0,        1'b0, 32'h00000400, 1'b0, 1'b1};
    vecs[11] = '{OP_LW,  4'b1111, 3'b001, 1'b1, 5'd15, 32'h0BADF00D, 1'b1, 32'h11111111, 1'b1, 32'h0BADF00D, 1'b0, 1'b1};

    // Reset state, then the first cycle after release must be a bubble.
    rst = 1'b1;
    applyStimulus(6'h00, mkInstr(OP_LW, 4'b1111, 3'b010, 1'b1, 5'd1, 32'h1), 1'b1, 32'h55555555);
    nextCycle();
    nextCycle();
    checkAllZero("in reset");
    rst = 1'b0;
    insA = mkInstr(8'h00, 4'b0000, 3'b001, 1'b1, 5'd2, 32'hA5A5A5A5);
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    #3;
    checkAllZero("post-reset bubble");
    nextCycle();
    #3;
    checkInstrOut("first alu", insA, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);

    for (int v = 0; v < 12; v++) begin
      insA = mkInstr(vecs[v].op, vecs[v].sel, vecs[v].selrf, vecs[v].we, vecs[v].waddr, vecs[v].ex);
      applyStimulus(6'h00, insA, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(6'h00, zeroI, vecs[v].rv, vecs[v].rd);
      #3;
      checkInstrOut($sformatf("vec%0d", v), insA, vecs[v].expWe, vecs[v].expData,
                    vecs[v].expStall, vecs[v].chkData);
    end

    // lh waits three cycles for data.
    insA = mkInstr(OP_LH, 4'b1100, 3'b010, 1'b1, 5'd3, 32'h0);
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    nextCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(6'h3F, zeroI, 1'b0, 32'h0);
      #3;
      checkInstrOut($sformatf("lh wait%0d", c), insA, 1'b0, 32'h0, 1'b1, 1'b0);
      nextCycle();
    end
    applyStimulus(6'h00, zeroI, 1'b1, 32'h80010000);
    #3;
    checkInstrOut("lh done", insA, 1'b1, 32'hFFFF8001, 1'b0, 1'b1);
    nextCycle();
    #3;
    checkAllZero("after lh");

    // Data arrives while the next stage is stalled; held value must survive.
    insA = mkInstr(OP_LW, 4'b1111, 3'b010, 1'b1, 5'd4, 32'h0);
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(6'h3F, zeroI, 1'b1, 32'hCAFEF00D);
    #3;
    checkInstrOut("held c1", insA, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(6'h3F, zeroI, 1'b0, 32'h0);
    #3;
    checkInstrOut("held c2", insA, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(6'h00, zeroI, 1'b1, 32'h0);
    #3;
    checkInstrOut("held adv", insA, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    nextCycle();

    // Hold then bubble insertion.
    insA = mkInstr(8'h00, 4'b0000, 3'b001, 1'b1, 5'd20, 32'h55AA55AA);
    insB = mkInstr(8'h00, 4'b0000, 3'b001, 1'b1, 5'd21, 32'h01020304);
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(6'h30, insB, 1'b0, 32'h0);
    #3;
    checkInstrOut("hold c1", insA, 1'b1, 32'h55AA55AA, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(6'h10, insB, 1'b0, 32'h0);
    #3;
    checkInstrOut("hold c2", insA, 1'b1, 32'h55AA55AA, 1'b0, 1'b1);
    nextCycle();
    #3;
    checkAllZero("bubble");

    // Advance with live data leaves the FSM idle for the next load.
    insA = mkInstr(OP_LW, 4'b1111, 3'b010, 1'b1, 5'd22, 32'h0);
    insB = mkInstr(OP_LW, 4'b1111, 3'b010, 1'b1, 5'd23, 32'h0);
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(6'h00, insB, 1'b1, 32'h11112222);
    #3;
    checkInstrOut("adv live", insA, 1'b1, 32'h11112222, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(6'h3F, zeroI, 1'b0, 32'h0);
    #3;
    checkInstrOut("next waits", insB, 1'b0, 32'h0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(6'h00, zeroI, 1'b1, 32'h33334444);
    #3;
    checkInstrOut("next done", insB, 1'b1, 32'h33334444, 1'b0, 1'b1);
    nextCycle();

    // Reset mid-HELD and mid-WAIT.
    insA = mkInstr(OP_LW, 4'b1111, 3'b010, 1'b1, 5'd24, 32'h0);
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(6'h3F, zeroI, 1'b1, 32'hAAAA5555);
    nextCycle();
    rst = 1'b1;
    #1;
    checkAllZero("rst held");
    nextCycle();
    rst = 1'b0;
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(6'h3F, zeroI, 1'b0, 32'h0);
    #3;
    checkInstrOut("after rst held", insA, 1'b0, 32'h0, 1'b1, 1'b0);
    nextCycle();
    rst = 1'b1;
    #1;
    checkAllZero("rst wait");
    nextCycle();
    rst = 1'b0;
    insB = mkInstr(8'h00, 4'b0000, 3'b001, 1'b1, 5'd25, 32'hFEEDFACE);
    applyStimulus(6'h00, insB, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(6'h00, zeroI, 1'b0, 32'h0);
    #3;
    checkInstrOut("alu after rst", insB, 1'b1, 32'hFEEDFACE, 1'b0, 1'b1);
    nextCycle();

    // Misaligned lw.
    insA = mkInstr(OP_LW, 4'b0011, 3'b010, 1'b1, 5'd26, 32'h0);
    applyStimulus(6'h00, insA, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(6'h00, zeroI, 1'b1, 32'h12345678);
    #3;
`ifdef MISALIGN_CHK_EN
    checkOutput("misalign flag", 102'(load_misalign), 102'(1));
    checkOutput("misalign wb we", 102'(mem12wb_bus[101]), 102'(0));
    checkOutput("misalign rf we", 102'(mem12rf_bus[37]), 102'(0));
`else
    checkOutput("misalign flag", 102'(load_misalign), 102'(0));
    checkOutput("misalign wb we", 102'(mem12wb_bus[101]), 102'(1));
    checkOutput("misalign rf we", 102'(mem12rf_bus[37]), 102'(1));
`endif
    nextCycle();

    // Randomized run against the behavioural model.
    rst = 1'b1;
    applyStimulus(6'h00, zeroI, 1'b0, 32'h0);
    nextCycle();
    rst = 1'b0;
    begin
      instr_t      cur, nx;
      bit          have;
      logic [31:0] held, word, expData;
      logic [5:0]  st;
      logic        rv, isLoad, expStall, expMis, expWe, adv;
      logic [31:0] rd;
      int          r;
      cur = '0;
      have = 1'b0;
      held = 32'h0;
      for (int n = 0; n < 300; n++) begin
        r = $urandom_range(0, 99);
        st = (r < 50) ? 6'h00 : ((r < 85) ? 6'h30 : 6'h10);
        st[3:0] = 4'($urandom);
        nx = genInstr();
        rv = ($urandom_range(0, 4) < 2);
        rd = $urandom;
        applyStimulus(st, nx, rv, rd);
        #3;
        isLoad = (cur.op[4:0] != 5'b0);
        word = (rv && !have) ? rd : held;
        expStall = isLoad && !have && !rv;
`ifdef MISALIGN_CHK_EN
        expMis = isLoad && isMisaligned(cur);
`else
        expMis = 1'b0;
`endif
        expWe = cur.we && !expStall && !expMis;
        expData = cur.selrf[1] ? loadValue(cur, word) : cur.ex;
        checkOutput($sformatf("rnd%0d stallreq", n), 102'(stallreq_mem), 102'(expStall));
        checkOutput($sformatf("rnd%0d wb we", n), 102'(mem12wb_bus[101]), 102'(expWe));
        checkOutput($sformatf("rnd%0d rf we", n), 102'(mem12rf_bus[37]), 102'(expWe));
        checkOutput($sformatf("rnd%0d misalign", n), 102'(load_misalign), 102'(expMis));
        checkOutput($sformatf("rnd%0d waddr", n), 102'(mem12rf_bus[36:32]), 102'(cur.waddr));
        checkOutput($sformatf("rnd%0d pc", n), 102'(mem12wb_bus[63:32]), 102'(cur.pc));
        checkOutput($sformatf("rnd%0d inst", n), 102'(mem12wb_bus[31:0]), 102'(cur.inst));
        if (!expStall && !(isLoad && isMisaligned(cur))) begin
          checkOutput($sformatf("rnd%0d wdata", n), 102'(mem12wb_bus[95:64]), 102'(expData));
          checkOutput($sformatf("rnd%0d rf wdata", n), 102'(mem12rf_bus[31:0]), 102'(expData));
        end
        adv = !st[4] || !st[5];
        if (isLoad && rv && !have && !adv) begin
          have = 1'b1;
          held = rd;
        end
        if (adv) have = 1'b0;
        if (st[4] && !st[5]) cur = '0;
        else if (!st[4]) cur = nx;
        nextCycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
